stack_frame_reader: RTL

//  Read-side initiator for SuperStack: walks a frame [lower, upper) of the operand stack using

---
 rtl/stack_frame_reader_if.sv | 28 ++
 rtl/stack_frame_reader.sv | 121 ++++++++++++
 2 files changed

// File: rtl/stack_frame_reader_if.sv
// Bundles the SuperStack read-side request/response signals and the outbound word stream.
interface stack_frame_reader_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 7
);
  logic [2:0]       stack_op;
  logic [DEPTH:0]   stack_offset;
  logic [DEPTH:0]   stack_lower_limit;
  logic [DEPTH:0]   stack_upper_limit;
  logic [WIDTH-1:0] stack_out;
  logic [2:0]       stack_status;
  logic [WIDTH-1:0] m_data;
  logic             m_valid;
  logic             m_ready;
  logic             m_last;

  modport master (
    output stack_op, stack_offset, stack_lower_limit, stack_upper_limit,
    output m_data, m_valid, m_last,
    input  stack_out, stack_status, m_ready
  );

  modport slave (
    input  stack_op, stack_offset, stack_lower_limit, stack_upper_limit,
    input  m_data, m_valid, m_last,
    output stack_out, stack_status, m_ready
  );
endinterface

// File: rtl/stack_frame_reader.sv
// Walks a SuperStack frame [lower, upper) with UNDERFLOW_GET and streams each word, lowest first.
module stack_frame_reader #(
  parameter int unsigned WIDTH             = 8,
  parameter int unsigned DEPTH             = 7,
  parameter logic [2:0]  OP_NONE           = 3'd0,
  parameter logic [2:0]  OP_UNDERFLOW_GET  = 3'd6,
  parameter logic [2:0]  STATUS_BAD_OFFSET = 3'd5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [DEPTH:0]       frame_lower,
  input  logic [DEPTH:0]       frame_upper,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  stack_frame_reader_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_HOLD,
    S_DONE
  } state_t;

  localparam logic [DEPTH:0] ONE = {{DEPTH{1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [DEPTH:0]   lower_q, lower_d;
  logic [DEPTH:0]   upper_q, upper_d;
  logic [DEPTH:0]   count_q, count_d;
  logic [DEPTH:0]   k_q, k_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             last_q, last_d;
  logic             err_q, err_d;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      lower_q <= '0;
      upper_q <= '0;
      count_q <= '0;
      k_q     <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lower_q <= lower_d;
      upper_q <= upper_d;
      count_q <= count_d;
      k_q     <= k_d;
      data_q  <= data_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    lower_d = lower_q;
    upper_d = upper_q;
    count_d = count_q;
    k_d     = k_q;
    data_d  = data_q;
    last_d  = last_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          lower_d = frame_lower;
          upper_d = frame_upper;
          count_d = frame_upper - frame_lower;
          k_d     = '0;
          err_d   = 1'b0;
          // Empty or inverted frames finish at once without touching the stack.
          state_d = (frame_upper <= frame_lower) ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        // SuperStack registers its result, so it is only valid in the cycle after the request.
        if (bus.stack_status == STATUS_BAD_OFFSET) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          data_d  = bus.stack_out;
          last_d  = (k_q == (count_q - ONE));
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (bus.m_ready) begin
          if (last_q) begin
            state_d = S_DONE;
          end else begin
            k_d     = k_q + ONE;
            state_d = S_ISSUE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.stack_op          = (state_q == S_ISSUE) ? OP_UNDERFLOW_GET : OP_NONE;
  assign bus.stack_offset      = (state_q == S_ISSUE) ? k_q : '0;
  assign bus.stack_lower_limit = lower_q;
  assign bus.stack_upper_limit = upper_q;
  assign bus.m_data            = data_q;
  assign bus.m_valid           = (state_q == S_HOLD);
  assign bus.m_last            = (state_q == S_HOLD) && last_q;

  assign busy  = (state_q != S_IDLE);
  assign done  = (state_q == S_DONE);
  assign error = (state_q == S_DONE) && err_q;

endmodule
